// File: rtl/vec_mem_sequencer.sv
// ============================================================================
//  Module   : vec_mem_sequencer
//  Purpose  : Splits vector load/store requests into 4-element beats across
//             four 16-bit memory banks and arbitrates them with scalar accesses.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vec_mem_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           v_req_valid,
    output logic           v_req_ready,
    input  logic           v_req_is_store,
    input  logic [15:0]    v_req_base,
    input  logic [15:0]    v_req_len,
    input  logic [255:0]   v_req_wdata,
    output logic           v_done,
    output logic [255:0]   v_rdata,
    input  logic           s_req_valid,
    output logic           s_req_ready,
    input  logic           s_req_is_store,
    input  logic [15:0]    s_req_addr,
    input  logic [15:0]    s_req_wdata,
    output logic           s_rvalid,
    output logic [15:0]    s_rdata,
    output logic [51:0]    bank_addr,
    output logic [3:0]     bank_wen,
    output logic [63:0]    bank_wdata,
    input  logic [63:0]    bank_rdata,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCALAR = 3'd1,
        S_VLOAD  = 3'd2,
        S_VDRAIN = 3'd3,
        S_VSTORE = 3'd4,
        S_VDONE  = 3'd5
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_pri_vec;
    logic [15:0]    r_base;
    logic [4:0]     r_len;
    logic [255:0]   r_wdata;
    logic [1:0]     r_beat, r_last_beat;
    logic           r_rd_pend;
    logic [1:0]     r_rd_beat;
    logic [255:0]   r_acc, r_vrdata, w_acc_nxt;
    logic           r_s_store, r_srvalid;
    logic [15:0]    r_s_addr, r_s_wdata;

    logic [4:0]     w_v_n;
    logic [1:0]     w_v_last;
    logic           w_s_grant, w_v_grant, w_vec_active;
    logic [1:0]     w_s_bank;

    // Byte-address bit 0 never selects anything
    logic w_unused;
    assign w_unused = &{1'b0, v_req_base[0], s_req_addr[0]};

    assign w_v_n    = (v_req_len > 16'd16) ? 5'd16 : v_req_len[4:0];
    assign w_v_last = 2'((w_v_n - 5'd1) >> 2);

    assign s_req_ready  = (r_state == S_IDLE) && !(v_req_valid && r_pri_vec);
    assign v_req_ready  = (r_state == S_IDLE) && !(s_req_valid && !r_pri_vec);
    assign w_s_grant    = s_req_valid && s_req_ready;
    assign w_v_grant    = v_req_valid && v_req_ready;
    assign w_vec_active = (r_state == S_VSTORE) || (r_state == S_VLOAD);
    assign w_s_bank     = r_s_addr[2:1];

    assign busy     = (r_state != S_IDLE);
    assign v_done   = (r_state == S_VDONE);
    assign v_rdata  = r_vrdata;
    assign s_rvalid = r_srvalid;
    assign s_rdata  = r_srvalid ? bank_rdata[16*w_s_bank +: 16] : 16'h0000;

    // Issue-side element geometry (current beat) and capture-side (previous beat)
    logic [3:0]  w_eidx  [4];
    logic [15:0] w_eaddr [4];
    logic [1:0]  w_ebank [4];
    logic        w_evalid[4];
    logic [3:0]  w_cidx  [4];
    logic [15:0] w_caddr [4];
    logic [1:0]  w_cbank [4];
    logic        w_cvalid[4];

    for (genvar j = 0; j < 4; j++) begin : g_elem
        assign w_eidx[j]   = {r_beat, 2'(j)};
        assign w_eaddr[j]  = r_base + {11'd0, w_eidx[j], 1'b0};
        assign w_ebank[j]  = w_eaddr[j][2:1];
        assign w_evalid[j] = ({1'b0, w_eidx[j]} < r_len);
        assign w_cidx[j]   = {r_rd_beat, 2'(j)};
        assign w_caddr[j]  = r_base + {11'd0, w_cidx[j], 1'b0};
        assign w_cbank[j]  = w_caddr[j][2:1];
        assign w_cvalid[j] = ({1'b0, w_cidx[j]} < r_len);
    end

    always_comb begin
        bank_addr  = '0;
        bank_wen   = '0;
        bank_wdata = '0;
        if (w_vec_active) begin
            for (int j = 0; j < 4; j++) begin
                bank_addr[13*w_ebank[j] +: 13] = w_eaddr[j][15:3];
                if ((r_state == S_VSTORE) && w_evalid[j]) begin
                    bank_wen[w_ebank[j]]            = 1'b1;
                    bank_wdata[16*w_ebank[j] +: 16] = r_wdata[16*w_eidx[j] +: 16];
                end
            end
        end else if (r_state == S_SCALAR) begin
            bank_addr[13*w_s_bank +: 13] = r_s_addr[15:3];
            bank_wen[w_s_bank]           = r_s_store;
            bank_wdata[16*w_s_bank +: 16] = r_s_wdata;
        end
    end

    always_comb begin
        w_acc_nxt = r_acc;
        if (r_rd_pend) begin
            for (int j = 0; j < 4; j++) begin
                if (w_cvalid[j]) begin
                    w_acc_nxt[16*w_cidx[j] +: 16] = bank_rdata[16*w_cbank[j] +: 16];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_s_grant) begin
                    w_state_nxt = S_SCALAR;
                end else if (w_v_grant) begin
                    if (w_v_n == 5'd0)       w_state_nxt = S_VDONE;
                    else if (v_req_is_store) w_state_nxt = S_VSTORE;
                    else                     w_state_nxt = S_VLOAD;
                end
            end
            S_SCALAR: w_state_nxt = S_IDLE;
            S_VSTORE: if (r_beat == r_last_beat) w_state_nxt = S_VDONE;
            S_VLOAD:  if (r_beat == r_last_beat) w_state_nxt = S_VDRAIN;
            S_VDRAIN: w_state_nxt = S_VDONE;
            S_VDONE:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pri_vec   <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_beat   <= '0;
            r_acc       <= '0;
            r_vrdata    <= '0;
            r_s_store   <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_srvalid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= (r_state == S_VLOAD);
            r_rd_beat <= r_beat;
            r_srvalid <= (r_state == S_SCALAR) && !r_s_store;
            if (w_s_grant) begin
                r_s_store <= s_req_is_store;
                r_s_addr  <= s_req_addr;
                r_s_wdata <= s_req_wdata;
                if (v_req_valid) r_pri_vec <= 1'b1;
            end
            if (w_v_grant) begin
                r_pri_vec   <= 1'b0;
                r_base      <= v_req_base;
                r_len       <= w_v_n;
                r_wdata     <= v_req_wdata;
                r_beat      <= '0;
                r_last_beat <= w_v_last;
                r_acc       <= '0;
                if (!v_req_is_store && (w_v_n == 5'd0)) r_vrdata <= '0;
            end else if (w_vec_active) begin
                r_beat <= r_beat + 2'd1;
            end
            if (r_rd_pend) r_acc <= w_acc_nxt;
            // Final beat merges straight into the visible result
            if (r_state == S_VDRAIN) r_vrdata <= w_acc_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
// ============================================================================
//  Module   : tb_vec_mem_sequencer
//  Purpose  : Directed and randomized bench for vec_mem_sequencer with a
//             banked memory model and an address-level reference memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vec_mem_sequencer;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           v_req_valid, v_req_ready, v_req_is_store;
    logic [15:0]    v_req_base, v_req_len;
    logic [255:0]   v_req_wdata;
    logic           v_done;
    logic [255:0]   v_rdata;
    logic           s_req_valid, s_req_ready, s_req_is_store;
    logic [15:0]    s_req_addr, s_req_wdata;
    logic           s_rvalid;
    logic [15:0]    s_rdata;
    logic [51:0]    bank_addr;
    logic [3:0]     bank_wen;
    logic [63:0]    bank_wdata;
    logic [63:0]    bank_rdata;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    vec_mem_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .v_req_valid(v_req_valid), .v_req_ready(v_req_ready),
        .v_req_is_store(v_req_is_store), .v_req_base(v_req_base),
        .v_req_len(v_req_len), .v_req_wdata(v_req_wdata),
        .v_done(v_done), .v_rdata(v_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_is_store(s_req_is_store), .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .bank_addr(bank_addr), .bank_wen(bank_wen), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Physical banks: synchronous write, one-cycle registered read
    bit [15:0] mem [4][8192];
    bit        mwr [4][8192];

    function automatic logic [15:0] dflt(input int b, input int row);
        return 16'(row * 7 + b * 4369 + 23130);
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_wen[b]) begin
                mem[b][bank_addr[13*b +: 13]] <= bank_wdata[16*b +: 16];
                mwr[b][bank_addr[13*b +: 13]] <= 1'b1;
            end
            bank_rdata[16*b +: 16] <= mwr[b][bank_addr[13*b +: 13]] ? mem[b][bank_addr[13*b +: 13]]
                                                                      : dflt(b, int'(bank_addr[13*b +: 13]));
        end
    end

    // Reference: a flat halfword-addressed memory with the same defaults
    bit [15:0] rmem [32768];
    bit        rwr  [32768];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        int h = int'(a) / 2;
        return rwr[h] ? rmem[h] : dflt(h % 4, h / 4);
    endfunction

    task automatic ref_wr(input logic [15:0] a, input logic [15:0] d);
        rmem[int'(a) / 2] = d;
        rwr[int'(a) / 2]  = 1'b1;
    endtask

    function automatic logic [15:0] phys_rd(input logic [15:0] a);
        int h = int'(a) / 2;
        return mwr[h % 4][h / 4] ? mem[h % 4][h / 4] : dflt(h % 4, h / 4);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vec_issue(input bit st, input logic [15:0] base, input logic [15:0] len,
                             input logic [255:0] wd);
        int w = 0;
        v_req_valid = 1'b1; v_req_is_store = st; v_req_base = base;
        v_req_len = len; v_req_wdata = wd;
        #1;
        while (!v_req_ready && w < 20) begin
            @(posedge clk); #2; w++;
        end
        chk("v_ready", 256'(v_req_ready), 256'(1));
        @(posedge clk); #2;
        // Scramble request fields: they must have been latched already
        v_req_valid = 1'b0; v_req_is_store = 1'($urandom);
        v_req_base = 16'($urandom); v_req_len = 16'($urandom);
        for (int i = 0; i < 8; i++) v_req_wdata[32*i +: 32] = $urandom;
    endtask

    task automatic vec_finish(input bit st, input int n, input logic [255:0] exp_rd,
                              output logic [3:0] wen1);
        int done_c = -1, nwr = 0, first = -1, last = -1, beats;
        logic [255:0] rd_at_done = '0;
        beats = (n + 3) / 4;
        wen1 = '0;
        for (int cy = 1; cy <= 30 && done_c < 0; cy++) begin
            if (bank_wen != 4'd0) begin
                nwr += $countones(bank_wen);
                if (first < 0) first = cy;
                last = cy;
            end
            if (cy == 1) wen1 = bank_wen;
            if (v_done) begin
                done_c = cy;
                rd_at_done = v_rdata;
            end
            @(posedge clk); #2;
        end
        chk("vdone_cycle", 256'(done_c), 256'((n == 0) ? 1 : (st ? beats + 1 : beats + 2)));
        chk("write_count", 256'(nwr), 256'(st ? n : 0));
        if (st && n > 0) begin
            chk("first_write_cycle", 256'(first), 256'(1));
            chk("last_write_cycle", 256'(last), 256'(beats));
        end
        if (!st) begin
            chk("vrdata", rd_at_done, exp_rd);
            chk("vrdata_hold", v_rdata, exp_rd);
        end
    endtask

    task automatic vec_op(input bit st, input logic [15:0] base, input logic [15:0] len,
                          input logic [255:0] wd, output logic [3:0] wen1);
        int n, mism;
        logic [255:0] exp_rd = '0;
        n = (len > 16) ? 16 : int'(len);
        for (int i = 0; i < n; i++) exp_rd[16*i +: 16] = ref_rd(base + 16'(2*i));
        vec_issue(st, base, len, wd);
        vec_finish(st, n, exp_rd, wen1);
        if (st) begin
            mism = 0;
            for (int i = 0; i < n; i++)
                if (phys_rd(base + 16'(2*i)) !== wd[16*i +: 16]) mism++;
            if (n < 16 && phys_rd(base + 16'(2*n)) !== ref_rd(base + 16'(2*n))) mism++;
            chk("store_contents", 256'(mism), 256'(0));
            for (int i = 0; i < n; i++) ref_wr(base + 16'(2*i), wd[16*i +: 16]);
        end
    endtask

    task automatic sc_op(input bit st, input logic [15:0] a, input logic [15:0] d);
        int w = 0;
        s_req_valid = 1'b1; s_req_is_store = st; s_req_addr = a; s_req_wdata = d;
        #1;
        while (!s_req_ready && w < 20) begin
            @(posedge clk); #2; w++;
        end
        chk("s_ready", 256'(s_req_ready), 256'(1));
        @(posedge clk); #2;
        s_req_valid = 1'b0; s_req_addr = 16'($urandom); s_req_wdata = 16'($urandom);
        chk("s_wen", 256'(bank_wen), 256'(st ? (4'b0001 << ((int'(a) / 2) % 4)) : 4'b0000));
        @(posedge clk); #2;
        chk("s_rvalid", 256'(s_rvalid), 256'(!st));
        if (st) ref_wr(a, d);
        else    chk("s_rdata", 256'(s_rdata), 256'(ref_rd(a)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] wd, exp_rd;
        logic [3:0]   wen1;
        logic [15:0]  sa, vb;

        rst_n = 1'b0;
        v_req_valid = 0; v_req_is_store = 0; v_req_base = 0; v_req_len = 0; v_req_wdata = '0;
        s_req_valid = 0; s_req_is_store = 0; s_req_addr = 0; s_req_wdata = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_vdone", 256'(v_done), 256'(0));
        chk("rst_srvalid", 256'(s_rvalid), 256'(0));
        chk("rst_wen", 256'(bank_wen), 256'(0));
        chk("rst_vrdata", v_rdata, 256'(0));
        chk("rst_srdata", 256'(s_rdata), 256'(0));
        chk("rst_addr", 256'(bank_addr), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Full 16-element store from address 0
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h1000 + 16'(i);
        vec_op(1'b1, 16'h0000, 16'd16, wd, wen1);
        chk("b0_row0", 256'(mem[0][0]), 256'(16'h1000));
        chk("b3_row3", 256'(mem[3][3]), 256'(16'h100F));

        // Short load starting mid-row: elements 0/1 from bank3 row0 / bank0 row1
        vec_op(1'b0, 16'h0006, 16'd6, '0, wen1);
        chk("ld6_lane0", 256'(v_rdata[15:0]), 256'(phys_rd(16'h0006)));
        chk("ld6_upper_zero", 256'(v_rdata[255:96]), 256'(0));

        // Wrapping store
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'($urandom);
        vec_op(1'b1, 16'hFFFC, 16'd4, wd, wen1);
        chk("wrap_wen_cycle1", 256'(wen1), 256'(4'hF));
        chk("wrap_elem2", 256'(mem[0][0]), 256'(wd[47:32]));

        // Zero-length and over-length requests
        vec_op(1'b0, 16'h0010, 16'd0, '0, wen1);
        chk("len0_vrdata", v_rdata, 256'(0));
        vec_op(1'b1, 16'h0020, 16'd0, wd, wen1);
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'($urandom);
        vec_op(1'b1, 16'h0040, 16'd40, wd, wen1);
        vec_op(1'b0, 16'h0040, 16'd40, '0, wen1);
        chk("len40_readback", v_rdata, wd);

        // Simultaneous scalar and vector requests out of reset
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        sa = 16'($urandom_range(0, 255));
        vb = 16'($urandom_range(0, 255));
        exp_rd = '0;
        for (int i = 0; i < 8; i++) exp_rd[16*i +: 16] = ref_rd(vb + 16'(2*i));
        s_req_valid = 1; s_req_is_store = 0; s_req_addr = sa;
        v_req_valid = 1; v_req_is_store = 0; v_req_base = vb; v_req_len = 16'd8;
        #1;
        chk("both_s_ready", 256'({s_req_ready, v_req_ready}), 256'(2'b10));
        @(posedge clk); #2;
        chk("both_busy_ready", 256'({s_req_ready, v_req_ready}), 256'(2'b00));
        @(posedge clk); #2;
        chk("both_v_ready", 256'({s_req_ready, v_req_ready}), 256'(2'b01));
        chk("both_s_rvalid", 256'(s_rvalid), 256'(1));
        chk("both_s_rdata", 256'(s_rdata), 256'(ref_rd(sa)));
        @(posedge clk); #2;
        s_req_valid = 0; v_req_valid = 0;
        vec_finish(1'b0, 8, exp_rd, wen1);

        // Randomized mix over a small, wrapping address window
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                sc_op(1'($urandom), 16'($urandom_range(0, 95)) - 16'd32, 16'($urandom));
            end else begin
                for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
                vec_op(1'($urandom), 16'($urandom_range(0, 95)) - 16'd32,
                       16'($urandom_range(0, 20)), wd, wen1);
            end
        end

        // Reset in the middle of a 4-beat store
        vb = 16'h0100;
        for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
        vec_issue(1'b1, vb, 16'd16, wd);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", 256'(bank_wen), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_vrdata", v_rdata, 256'(0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("midrst_no_vdone", 256'(v_done), 256'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) ref_wr(vb + 16'(2*i), wd[16*i +: 16]);
        begin
            int mism = 0;
            for (int i = 0; i < 16; i++)
                if (phys_rd(vb + 16'(2*i)) !== ref_rd(vb + 16'(2*i))) mism++;
            chk("midrst_contents", 256'(mism), 256'(0));
        end
        @(posedge clk); #2;
        vec_op(1'b0, vb, 16'd16, '0, wen1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
